// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmit-path constants and the FIFO geometry helper.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_TX_FIFO_DEPTH = 16;

    // Power-of-two depths let the pointers wrap by natural overflow.
    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port (LUTRAM).
module uart_tx_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately left unreset; occupancy tracking decides validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit FIFO between the CPU store path and the UART transmitter.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  WIDTH = UART_DATA_WIDTH,
    parameter int  DEPTH = UART_TX_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    if (!is_pow2_ge2(DEPTH)) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             enq_fire;
    logic             deq_fire;

    // Status comes from the occupancy counter only, so wrapped pointers never alias full/empty.
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign count     = count_reg;

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (enq_fire) begin
            wptr_next = wptr_reg + PTR_W'(1);
        end
        if (deq_fire) begin
            rptr_next = rptr_reg + PTR_W'(1);
        end
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // Head word is read combinationally; it only moves when rptr advances on a dequeue.
    uart_tx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo_mem (
        .clk     (clk),
        .wr_en   (enq_fire),
        .wr_addr (wptr_reg),
        .wr_data (enq_data),
        .rd_addr (rptr_reg),
        .rd_data (deq_data)
    );

endmodule
